// File: rtl/spi_dac_ctrl.sv
// SPI write engine for MCP49x2-class dual 12-bit DACs (mode 0,0), one 16-bit frame per start.
// Latency: dac_cs low 1 cycle after accept; done pulses 33*CLK_DIV+CS_GAP cycles after accept.
// Backpressure: start is taken only when idle or in the done cycle; starts while busy are dropped.
// Optional feature: define LDAC_PULSE_EN to strobe dac_ldac_n low in the done cycle.
module spi_dac_ctrl #(
    parameter int DATA_W   = 12,
    parameter int CLK_DIV  = 1,
    parameter int CS_GAP   = 2,
    parameter bit VREF_BUF = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ch,
    input  logic [DATA_W-1:0] din,
    input  logic              gain_1x,
    input  logic              shdn_n,
    output logic              busy,
    output logic              done,
    output logic              dac_cs,
    output logic              dac_sclk,
    output logic              dac_sdi,
    output logic              dac_ldac_n
);

    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    // Only reachable when CS_GAP >= 2; marks the cycle before the last gap cycle.
    localparam logic [GAP_W-1:0] GAP_PEN  = GAP_W'(CS_GAP - 2);

`ifdef LDAC_PULSE_EN
    localparam bit LDAC_EN = 1'b1;
`else
    localparam bit LDAC_EN = 1'b0;
`endif

    if (DATA_W < 1 || DATA_W > 12) begin : g_bad_data_w
        $error("spi_dac_ctrl: DATA_W must be in 1..12");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_dac_ctrl: CLK_DIV must be >= 1");
    end
    if (CS_GAP < 1 || (LDAC_EN && CS_GAP < 2)) begin : g_bad_cs_gap
        $error("spi_dac_ctrl: CS_GAP too small for this configuration");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t             state;
    logic [14:0]        sh;
    logic [3:0]         bit_cnt;
    logic [PH_W-1:0]    ph_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               ldac_q;
    logic [11:0]        data_field;
    logic [15:0]        frame;
    logic               accept;

    always_comb begin
        data_field = '0;
        data_field[11 -: DATA_W] = din;
        frame = {ch, VREF_BUF, gain_1x, shdn_n, data_field};
    end

    // The done cycle also accepts, so held-high start yields exactly CS_GAP cs-high cycles.
    assign accept     = start && ((state == IDLE) || done);
    assign dac_ldac_n = LDAC_EN ? ldac_q : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            bit_cnt  <= '0;
            ph_cnt   <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dac_cs   <= 1'b1;
            dac_sclk <= 1'b0;
            dac_sdi  <= 1'b0;
            ldac_q   <= 1'b1;
        end else begin
            done   <= 1'b0;
            ldac_q <= 1'b1;
            if (accept) begin
                state    <= SHIFT;
                sh       <= frame[14:0];
                dac_sdi  <= frame[15];
                dac_cs   <= 1'b0;
                dac_sclk <= 1'b0;
                bit_cnt  <= '0;
                ph_cnt   <= '0;
                gap_cnt  <= '0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    SHIFT: begin
                        if (ph_cnt != PH_LAST) begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end else begin
                            ph_cnt <= '0;
                            if (!dac_sclk) begin
                                dac_sclk <= 1'b1;
                            end else begin
                                // Falling edge: the only place sdi is allowed to move.
                                dac_sclk <= 1'b0;
                                if (bit_cnt == 4'd15) begin
                                    state   <= HOLD;
                                    dac_sdi <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    dac_sdi <= sh[14];
                                    sh      <= {sh[13:0], 1'b0};
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (ph_cnt != PH_LAST) begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end else begin
                            ph_cnt  <= '0;
                            state   <= GAP;
                            dac_cs  <= 1'b1;
                            gap_cnt <= '0;
                            if (CS_GAP == 1) begin
                                done   <= 1'b1;
                                ldac_q <= 1'b0;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                            done    <= (gap_cnt == GAP_PEN);
                            ldac_q  <= (gap_cnt != GAP_PEN);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
